// File: rtl/up_down_counter_pkg.sv
// Shared constants and types for the up/down counter slice.
// The direction encoding matches the cntrl pin level directly.
package up_down_counter_pkg;

  localparam int CNT_WIDTH_DEFAULT = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/up_down_counter_next.sv
// Next-state logic for the up/down counter: a +/-1 step modulo 2**WIDTH.
// Purely combinational; wrap-around comes for free from the fixed-width add.
module up_down_counter_next
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] count_q,
  input  logic             cntrl,
  output logic [WIDTH-1:0] count_d
);

  dir_e dir;

  assign dir = dir_e'(cntrl);

  always_comb begin
    count_d = count_q;
    if (dir == DIR_UP) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/up_down_counter.sv
// Free-running up/down counter: async active-low clear, one step per edge.
// Port order is fixed because existing instances connect by position.
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             cntrl,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  up_down_counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .count_q(count_q),
    .cntrl  (cntrl),
    .count_d(count_d)
  );

  // Reset clears immediately and overrides any edge that coincides with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Self-checking bench for up_down_counter at WIDTH=4 and WIDTH=8: directed
// table, hand-written corner sequences, then random steps against a model.
module tb_up_down_counter;

  typedef struct {
    logic       c;
    logic       r;
    logic [7:0] want;
  } vec_t;

  logic       clk;
  logic       cntrl4, rst4;
  logic       cntrl8, rst8;
  logic [3:0] count4;
  logic [7:0] count8;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  vec_t       tbl[$];

  int m4, m8;

  up_down_counter #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .cntrl(cntrl4),
    .rst  (rst4),
    .count(count4)
  );

  up_down_counter #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .cntrl(cntrl8),
    .rst  (rst8),
    .count(count8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cntrl4 = 1'b1;
    rst4   = 1'b0;
    cntrl8 = 1'b1;
    rst8   = 1'b0;
  end

  // scoreboard compare
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  // reference model: step from the rules, plain modular arithmetic
  function automatic int ref_next(int cur, bit up, bit rst_n, int w);
    int m;
    m = 1 << w;
    if (!rst_n) return 0;
    return up ? (cur + 1) % m : (cur + m - 1) % m;
  endfunction

  // driver: apply inputs at the falling edge, check just after the rising edge
  task automatic step(input logic c4, input logic r4, input logic [7:0] e4,
                      input logic c8, input logic r8, input logic [7:0] e8,
                      input string tag);
    @(negedge clk);
    cntrl4 = c4;
    rst4   = r4;
    cntrl8 = c8;
    rst8   = r8;
    exp_q.push_back(e4);
    exp_q.push_back(e8);
    @(posedge clk);
    #1;
    check({tag, "_w4"}, {4'b0000, count4}, exp_q.pop_front());
    check({tag, "_w8"}, count8, exp_q.pop_front());
  endtask

  function automatic void add(input logic c, input logic r, input int e);
    vec_t v;
    v.c    = c;
    v.r    = r;
    v.want = 8'(e);
    tbl.push_back(v);
  endfunction

  initial begin
    #1;
    check("reset_state_w4", {4'b0000, count4}, 8'd0);
    check("reset_state_w8", count8, 8'd0);

    // directed table for WIDTH=4 (8-bit instance held in reset meanwhile)
    add(1, 0, 0); add(1, 0, 0);
    for (int v = 1; v <= 6; v++) add(1, 1, v);
    for (int v = 7; v <= 14; v++) add(1, 1, v);
    add(1, 1, 15); add(1, 1, 0); add(1, 1, 1);
    for (int v = 2; v <= 6; v++) add(1, 1, v);
    add(0, 1, 5); add(0, 1, 4); add(0, 1, 3); add(0, 1, 2); add(0, 1, 1);
    add(0, 1, 0); add(0, 1, 15); add(0, 1, 14); add(0, 1, 13); add(0, 1, 12);
    add(1, 1, 13); add(1, 1, 14); add(1, 1, 15);
    add(1, 0, 0);
    for (int v = 1; v <= 5; v++) add(1, 1, v);
    add(1, 1, 6); add(0, 1, 5); add(1, 1, 6); add(0, 1, 5);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].c, tbl[i].r, tbl[i].want, 1'b1, 1'b0, 8'd0, $sformatf("tbl%0d", i));
    end

    // reset asserted between edges must clear without a clock
    @(negedge clk);
    #2;
    rst4 = 1'b0;
    #1;
    check("async_clear_w4", {4'b0000, count4}, 8'd0);
    step(1, 0, 0, 1, 0, 0, "reset_hold");
    step(0, 1, 15, 1, 0, 0, "release_down");
    step(1, 1, 0, 1, 0, 0, "up_from_max");

    // WIDTH=8 corner sequence (4-bit instance held in reset)
    step(1, 0, 0, 1, 0, 0, "w8_reset");
    for (int v = 1; v <= 255; v++) step(1, 0, 0, 1, 1, 8'(v), $sformatf("w8_up%0d", v));
    step(1, 0, 0, 1, 1, 8'd0, "w8_wrap_up");
    step(1, 0, 0, 1, 1, 8'd1, "w8_after_wrap");
    step(1, 0, 0, 0, 1, 8'd0, "w8_down0");
    step(1, 0, 0, 0, 1, 8'd255, "w8_wrap_down");
    step(1, 0, 0, 0, 1, 8'd254, "w8_down254");

    // randomized stimulus against the model
    m4 = 0;
    m8 = 254;
    for (int i = 0; i < 300; i++) begin
      bit c4, r4, c8, r8;
      c4 = 1'($urandom_range(0, 1));
      c8 = 1'($urandom_range(0, 1));
      r4 = ($urandom_range(0, 15) != 0);
      r8 = ($urandom_range(0, 15) != 0);
      if (i == 0) r4 = 1'b1;
      m4 = ref_next(m4, c4, r4, 4);
      m8 = ref_next(m8, c8, r8, 8);
      step(c4, r4, 8'(m4), c8, r8, 8'(m8), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
